// File: rtl/chess_tick_pkg.sv
// Shared types and helpers for the chess clock countdown core.
//   t_cd_state    : countdown FSM states
//   t_bcd, t_bcd2 : one BCD digit, and a tens/units pair ([1] = tens, [0] = units)
//   bcd_sanitise  : clamps a digit above 9 down to 9
//   bcd2_to_bin   : two-digit BCD to binary 0..99
//   bcd2_dec      : two-digit BCD decrement with borrow from tens
package chess_tick_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_ZERO
  } t_cd_state;

  typedef logic [3:0] t_bcd;
  typedef t_bcd [1:0] t_bcd2;

  function automatic t_bcd bcd_sanitise(input t_bcd d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic t_bcd2 bcd2_sanitise(input t_bcd2 v);
    t_bcd2 r;
    r[1] = bcd_sanitise(v[1]);
    r[0] = bcd_sanitise(v[0]);
    return r;
  endfunction

  function automatic logic [6:0] bcd2_to_bin(input t_bcd2 v);
    return 7'(v[1]) * 7'd10 + 7'(v[0]);
  endfunction

  // Caller guarantees v != 00; 00 never decrements.
  function automatic t_bcd2 bcd2_dec(input t_bcd2 v);
    t_bcd2 r;
    if (v[0] != 4'd0) begin
      r[1] = v[1];
      r[0] = v[0] - 4'd1;
    end else begin
      r[1] = v[1] - 4'd1;
      r[0] = 4'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/chess_tick_prescaler.sv
// Tick prescaler: counts 0..p_divider-1 while enabled, holding its count when
// disabled so partial periods survive pauses.
//   clk_i   : system clock
//   rst_ni  : synchronous active-low reset, clears the count
//   en_i    : advance the count this cycle
//   clr_i   : synchronous clear (takes priority over en_i)
//   tc_o    : terminal-count pulse, high in the cycle the count wraps
module chess_tick_prescaler #(
  parameter int unsigned p_divider = 17_865_771
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int unsigned CntW = (p_divider > 2) ? $clog2(p_divider) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(p_divider - 1);

  logic [CntW-1:0] cnt_q;
  logic            at_max;

  assign at_max = (cnt_q == CntMax);
  assign tc_o   = en_i && !clr_i && at_max;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= at_max ? '0 : cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/chess_tick_countdown.sv
// Per-player countdown core for the chess clock. Holds a two-digit BCD time,
// loads it from the init switches, and decrements once per prescaled tick while
// the player's turn is running.
//   i_clk     : system clock
//   i_rst     : synchronous active-low reset (loads i_init)
//   i_init    : initial BCD time, [1] = tens, [0] = units (digits > 9 load as 9)
//   i_restart : single-cycle pulse, reload from i_init (beats tick and i_run)
//   i_run     : level, this player's clock is running
//   o_digit   : current BCD value
//   o_tick    : pulse in the cycle o_digit shows a freshly decremented value
//   o_zero    : value is 00
//   o_warn    : 0 < value <= p_warn
//   o_running : FSM is in S_RUN
module chess_tick_countdown
  import chess_tick_pkg::*;
#(
  parameter int unsigned p_divider = 17_865_771,
  parameter int unsigned p_warn    = 10
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [1:0][3:0] i_init,
  input  logic            i_restart,
  input  logic            i_run,
  output logic [1:0][3:0] o_digit,
  output logic            o_tick,
  output logic            o_zero,
  output logic            o_warn,
  output logic            o_running
);

  localparam logic [6:0] WarnBin = 7'(p_warn);

  t_cd_state state_q;
  t_bcd2     digit_q;
  logic      tick_q;

  t_bcd2     load_val;
  logic      load_zero;
  t_bcd2     dec_val;
  logic      presc_en;
  logic      presc_tc;

  assign load_val  = bcd2_sanitise(t_bcd2'(i_init));
  assign load_zero = (load_val == '0);
  assign dec_val   = bcd2_dec(digit_q);

  // Only a running turn advances the prescaler; the first increment lands the
  // cycle after entering S_RUN because state_q is still the old state before.
  assign presc_en = (state_q == S_RUN) && i_run;

  chess_tick_prescaler #(
    .p_divider(p_divider)
  ) u_prescaler (
    .clk_i (i_clk),
    .rst_ni(i_rst),
    .en_i  (presc_en),
    .clr_i (i_restart),
    .tc_o  (presc_tc)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_restart) begin
      digit_q <= load_val;
      state_q <= load_zero ? S_ZERO : S_IDLE;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_run) state_q <= S_RUN;
        end
        S_RUN: begin
          if (!i_run) begin
            state_q <= S_HOLD;
          end else if (presc_tc) begin
            digit_q <= dec_val;
            tick_q  <= 1'b1;
            if (dec_val == '0) state_q <= S_ZERO;
          end
        end
        S_HOLD: begin
          if (i_run) state_q <= S_RUN;
        end
        S_ZERO: begin
          state_q <= S_ZERO;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_digit   = digit_q;
  assign o_tick    = tick_q;
  assign o_zero    = (digit_q == '0);
  assign o_warn    = !o_zero && (bcd2_to_bin(digit_q) <= WarnBin);
  assign o_running = (state_q == S_RUN);

endmodule

// File: tb/tb_chess_tick_countdown.sv
// Self-checking bench for chess_tick_countdown with p_divider = 4, p_warn = 10.
// The reference model tracks the remaining time as an integer 0..99, the count
// of running cycles since the last tick, and whether the clock is running.
module tb_chess_tick_countdown;

  localparam int Div  = 4;
  localparam int Warn = 10;

  logic            clk = 1'b0;
  logic            i_rst = 1'b0;
  logic [1:0][3:0] i_init = '0;
  logic            i_restart = 1'b0;
  logic            i_run = 1'b0;
  logic [1:0][3:0] o_digit;
  logic            o_tick;
  logic            o_zero;
  logic            o_warn;
  logic            o_running;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_val = 0;
  int m_acc = 0;
  bit m_running = 1'b0;
  bit m_tick = 1'b0;
  int m_init_t = 0;
  int m_init_u = 0;
  int tick_cnt = 0;

  always #5 clk = ~clk;

  chess_tick_countdown #(
    .p_divider(Div),
    .p_warn   (Warn)
  ) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_init   (i_init),
    .i_restart(i_restart),
    .i_run    (i_run),
    .o_digit  (o_digit),
    .o_tick   (o_tick),
    .o_zero   (o_zero),
    .o_warn   (o_warn),
    .o_running(o_running)
  );

  function automatic int san(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_init(input int t, input int u);
    m_init_t = t;
    m_init_u = u;
    i_init[1] = 4'(t);
    i_init[0] = 4'(u);
  endtask

  // One clock edge of the behavioural model, from the inputs held across it.
  task automatic model_edge(input bit rst, input bit rs, input bit run);
    m_tick = 1'b0;
    if (!rst || rs) begin
      m_val = san(m_init_t) * 10 + san(m_init_u);
      m_acc = 0;
      m_running = 1'b0;
    end else if (m_val != 0) begin
      if (m_running && run) begin
        m_acc++;
        if (m_acc == Div) begin
          m_acc  = 0;
          m_val  = m_val - 1;
          m_tick = 1'b1;
        end
      end
      m_running = run && (m_val != 0);
    end else begin
      m_running = 1'b0;
    end
  endtask

  task automatic check_all();
    check("tens", 32'(o_digit[1]), 32'(m_val / 10));
    check("units", 32'(o_digit[0]), 32'(m_val % 10));
    check("tick", 32'(o_tick), 32'(m_tick));
    check("zero", 32'(o_zero), 32'(m_val == 0));
    check("warn", 32'(o_warn), 32'((m_val != 0) && (m_val <= Warn)));
    check("running", 32'(o_running), 32'(m_running));
  endtask

  task automatic step(input bit rst, input bit rs, input bit run);
    i_rst = rst;
    i_restart = rs;
    i_run = run;
    @(posedge clk);
    model_edge(rst, rs, run);
    #1;
    if (o_tick === 1'b1) tick_cnt++;
    check_all();
  endtask

  initial begin
    // 1. Reset with {1,2}
    set_init(1, 2);
    step(1'b0, 1'b0, 1'b0);
    check("rst_digit", 32'(o_digit), 32'(8'h12));
    check("rst_zero", 32'(o_zero), 32'd0);
    check("rst_warn", 32'(o_warn), 32'd0);
    check("rst_tick", 32'(o_tick), 32'd0);
    check("rst_running", 32'(o_running), 32'd0);

    // 2. Restart and run continuously: ticks on running steps 5, 9, 13
    step(1'b1, 1'b1, 1'b0);
    tick_cnt = 0;
    for (int i = 1; i <= 13; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (i == 5 || i == 9 || i == 13) check("t2_tick_on", 32'(o_tick), 32'd1);
      if (i == 4 || i == 8 || i == 12) check("t2_tick_off", 32'(o_tick), 32'd0);
      if (i == 9) begin
        check("t2_digit10", 32'(o_digit), 32'(8'h10));
        check("t2_warn", 32'(o_warn), 32'd1);
      end
    end
    check("t2_digit09", 32'(o_digit), 32'(8'h09));
    check("t2_ticks", 32'(tick_cnt), 32'd3);

    // 3. Pause after two running cycles; two more running cycles finish the period
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    check("t3_pause_digit", 32'(o_digit), 32'(8'h09));
    check("t3_hold_running", 32'(o_running), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    check("t3_reenter_tick", 32'(o_tick), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    check("t3_first_run_tick", 32'(o_tick), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    check("t3_tick", 32'(o_tick), 32'd1);
    check("t3_digit", 32'(o_digit), 32'(8'h08));

    // 4. Run down from 01 to 00 and stay there
    set_init(0, 1);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    check("t4_zero", 32'(o_zero), 32'd1);
    check("t4_warn", 32'(o_warn), 32'd0);
    check("t4_digit", 32'(o_digit), 32'd0);
    tick_cnt = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1);
    check("t4_no_ticks", 32'(tick_cnt), 32'd0);
    set_init(0, 5);
    step(1'b1, 1'b1, 1'b0);
    check("t4_reload_zero", 32'(o_zero), 32'd0);
    check("t4_reload_digit", 32'(o_digit), 32'(8'h05));
    check("t4_reload_running", 32'(o_running), 32'd0);

    // 5. Loading 00 expires at once; oversized digits clamp to 9
    set_init(0, 0);
    step(1'b1, 1'b1, 1'b1);
    check("t5_zero", 32'(o_zero), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1);
    check("t5_ignored_run", 32'(o_running), 32'd0);
    set_init(11, 13);
    step(1'b1, 1'b1, 1'b0);
    check("t5_clamp", 32'(o_digit), 32'(8'h99));

    // 6. Restart on the terminal-count cycle, then reset mid-run
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    set_init(4, 2);
    step(1'b1, 1'b1, 1'b1);
    check("t6_restart_digit", 32'(o_digit), 32'(8'h42));
    check("t6_restart_tick", 32'(o_tick), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    set_init(3, 7);
    step(1'b0, 1'b0, 1'b1);
    check("t6_rst_digit", 32'(o_digit), 32'(8'h37));
    check("t6_rst_running", 32'(o_running), 32'd0);
    tick_cnt = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    check("t6_no_early_tick", 32'(tick_cnt), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    check("t6_tick_after_rst", 32'(o_tick), 32'd1);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 0) set_init($urandom_range(0, 1), $urandom_range(0, 15));
        else set_init($urandom_range(0, 15), $urandom_range(0, 15));
      end
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 4) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
